quad_decoder: RTL and testbench
===============================

# quad_decoder

Quadrature decoder front end for the position-counting path. Samples two asynchronous encoder channels A and B, synchronises and glitch-filters them, and decodes Gray-code transitions into single-cycle step pulses with direction. It maintains an internal loadable up/down position register with wrap and overflow, and flags illegal transitions. It is the input-side counterpart of the generic up/down counter: it generates the count/direction events that the counter consumes.

## Interface
Parameters:
- counter_size, 32, width of position register pos_out/pos_in
- filter_cycles, 4, consecutive stable synced cycles required to accept a channel change (legal range 1..255)

Ports:
- clk  in  1  system clock, all logic on rising edge
- res_n  in  1  reset; one clock, synchronous, active-low
- enable  in  1  1 = steps update pos_out and pulse step; 0 = decoder tracks state silently
- a_in  in  1  encoder channel A, asynchronous
- b_in  in  1  encoder channel B, asynchronous
- load  in  1  load pos_in into pos_out this edge
- pos_in  in  counter_size  load value
- err_clr  in  1  clears sticky err
- step  out  1  one-cycle pulse per accepted legal transition
- dir  out  1  direction of last step; 1 = up (increment), 0 = down
- pos_out  out  counter_size  current position
- overflow  out  1  one-cycle pulse on wrap in either direction
- err  out  1  sticky illegal-transition flag

## Operation
- Sync: per channel 2-flop synchroniser (s1, s2); s2 feeds filter.
- Filter: per channel, a_filt/b_filt plus stability counter. Each edge s2 != filt: counter increments; when counter == filter_cycles-1 and still mismatched, filt <= s2, counter <= 0. Any edge s2 == filt: counter <= 0. Pulses on s2 shorter than filter_cycles cycles never reach filt.
- State machine, two states:
  - INIT (entered on reset): filt <= s2 directly each edge, no decode, no step, no err. Cycle counter leaves INIT after filter_cycles+2 edges with res_n high.
  - RUN: normal filter/decode. Only exit is reset.
- Decode in RUN: prev <= {a_filt,b_filt} each edge; compare prev to current {a_filt,b_filt}.
  - Up sequence {a,b}: 00->01->11->10->00. Down: reverse.
  - Legal up: dir <= 1, pos_out+1. Legal down: dir <= 0, pos_out-1. No change: nothing.
  - Both bits changed: err <= 1, no step, pos_out and dir unchanged.
- enable = 0: prev still tracks, err still detected; step stays 0, pos_out, dir and overflow frozen. Re-enabling causes no spurious step.
- Position arithmetic modulo 2^counter_size. Up from all-ones -> 0, down from 0 -> all-ones; either pulses overflow for that cycle.
- load: priority over a coincident step. pos_out <= pos_in, step <= 0, overflow <= 0; the coincident transition is consumed (prev updated), not deferred. dir unchanged.
- err_clr: err <= 0 unless an illegal transition is detected the same edge (set wins).

## Timing
- Reset values: step 0, dir 0, pos_out 0, overflow 0, err 0. s1/s2/filt/prev/counters 0, state INIT.
- Reset mid-operation: all state returns to reset values at the next edge with res_n low. INIT re-adopts current channel levels without err or step.
- Latency: a channel change first captured in s1 at edge k -> filt updates at edge k+1+filter_cycles -> step/pos_out/overflow registered at edge k+2+filter_cycles (default: 6 edges).
- step, overflow: registered, high exactly one cycle per event. pos_out changes on the same edge step rises.
- Max decodable rate: one transition per filter_cycles+1 cycles per channel. Faster input is filtered or flagged, not queued.
- load visible on pos_out the edge after load sampled high.

## Test plan
- Reset with a_in=1, b_in=1 held, release, wait 10 cycles -> pos_out=0, step never 1, err=0, overflow=0.
- From 00, drive 01,11,10,00, each held 8 cycles -> four step pulses, dir=1, pos_out=4; each step 6 edges after the A/B change.
- Reverse the sequence from pos_out=4 -> four steps, dir=0, pos_out=0. One more down step -> pos_out=0xFFFFFFFF, overflow pulses once.
- 3-cycle glitch on a_in (filter_cycles=4) -> no step, no err, pos_out unchanged. 4-cycle pulse -> accepted as two transitions (+1 then -1), pos_out returns.
- Change a_in and b_in together 00->11 -> err=1, no step. err_clr pulse -> err=0. Illegal transition coincident with err_clr -> err stays 1.
- load pos_in=0xFFFFFFFF, then one up step -> pos_out=0, overflow=1 for one cycle. load coincident with a step -> pos_out=pos_in, step=0. enable=0 during two up steps -> pos_out frozen, no step; re-enable -> no spurious step.

Source files
------------

// File: rtl/quad_decoder.sv
// Quadrature decoder front end: channel sync, glitch filter, Gray decode,
// and a loadable wrapping position register with sticky illegal-step flag.
module quad_decoder #(
   parameter int counter_size  = 32,
   parameter int filter_cycles = 4
) (
   input  logic                    clk,
   input  logic                    res_n,
   input  logic                    enable,
   input  logic                    a_in,
   input  logic                    b_in,
   input  logic                    load,
   input  logic [counter_size-1:0] pos_in,
   input  logic                    err_clr,
   output logic                    step,
   output logic                    dir,
   output logic [counter_size-1:0] pos_out,
   output logic                    overflow,
   output logic                    err
);

   localparam logic [7:0] FLIM = 8'(filter_cycles - 1);
   localparam logic [8:0] ILIM = 9'(filter_cycles + 1);

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   state_t                  r_state;
   logic [8:0]              r_icnt;
   logic [1:0]              r_s1;
   logic [1:0]              r_s2;
   logic [1:0]              r_prev;
   logic [1:0]              w_filt;
   logic                    w_run;
   logic                    w_up;
   logic                    w_dn;
   logic                    w_ill;
   logic                    r_step;
   logic                    r_dir;
   logic                    r_ovf;
   logic                    r_err;
   logic [counter_size-1:0] r_pos;

   assign w_run = (r_state == ST_RUN);

   // Two-flop synchroniser; bit 1 carries A, bit 0 carries B
   always_ff @(posedge clk) begin
      if (!res_n) begin
         r_s1 <= 2'b00;
         r_s2 <= 2'b00;
      end else begin
         r_s1 <= {a_in, b_in};
         r_s2 <= r_s1;
      end
   end

   // Settling window after reset before decoding starts
   always_ff @(posedge clk) begin
      if (!res_n) begin
         r_state <= ST_INIT;
         r_icnt  <= '0;
      end else if (r_state == ST_INIT) begin
         if (r_icnt == ILIM) begin
            r_state <= ST_RUN;
            r_icnt  <= '0;
         end else begin
            r_icnt <= r_icnt + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_filt
      logic       r_f;
      logic [7:0] r_cnt;

      // Accept a level only after it has differed for filter_cycles edges
      always_ff @(posedge clk) begin
         if (!res_n) begin
            r_f   <= 1'b0;
            r_cnt <= '0;
         end else if (!w_run) begin
            r_f   <= r_s2[g];
            r_cnt <= '0;
         end else if (r_s2[g] == r_f) begin
            r_cnt <= '0;
         end else if (r_cnt == FLIM) begin
            r_f   <= r_s2[g];
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end

      assign w_filt[g] = r_f;
   end

   // Classify previous vs current filtered code {a,b}
   always_comb begin
      w_up  = 1'b0;
      w_dn  = 1'b0;
      w_ill = 1'b0;
      unique case ({r_prev, w_filt})
         4'b0001, 4'b0111, 4'b1110, 4'b1000: w_up  = w_run;
         4'b0010, 4'b1011, 4'b1101, 4'b0100: w_dn  = w_run;
         4'b0011, 4'b1100, 4'b0110, 4'b1001: w_ill = w_run;
         default: ;
      endcase
   end

   // Previous code follows the synced level during INIT so RUN starts clean
   always_ff @(posedge clk) begin
      if (!res_n) begin
         r_prev <= 2'b00;
      end else if (!w_run) begin
         r_prev <= r_s2;
      end else begin
         r_prev <= w_filt;
      end
   end

   // Position, step and overflow; load beats a coincident step
   always_ff @(posedge clk) begin
      if (!res_n) begin
         r_pos  <= '0;
         r_step <= 1'b0;
         r_dir  <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_step <= 1'b0;
         r_ovf  <= 1'b0;
         if (load) begin
            r_pos <= pos_in;
         end else if (enable && w_up) begin
            r_pos  <= r_pos + 1'b1;
            r_step <= 1'b1;
            r_dir  <= 1'b1;
            r_ovf  <= &r_pos;
         end else if (enable && w_dn) begin
            r_pos  <= r_pos - 1'b1;
            r_step <= 1'b1;
            r_dir  <= 1'b0;
            r_ovf  <= ~|r_pos;
         end
      end
   end

   // Sticky error; a fresh illegal step wins over a clear
   always_ff @(posedge clk) begin
      if (!res_n) begin
         r_err <= 1'b0;
      end else if (w_ill) begin
         r_err <= 1'b1;
      end else if (err_clr) begin
         r_err <= 1'b0;
      end
   end

   assign step     = r_step;
   assign dir      = r_dir;
   assign pos_out  = r_pos;
   assign overflow = r_ovf;
   assign err      = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios plus random encoder traffic,
// compared every cycle against a behavioural model.
module tb_quad_decoder;

   localparam int CW = 32;
   localparam int FC = 4;

   logic          clk = 1'b0;
   logic          res_n = 1'b0;
   logic          enable = 1'b1;
   logic          a_in = 1'b0;
   logic          b_in = 1'b0;
   logic          load = 1'b0;
   logic [CW-1:0] pos_in = '0;
   logic          err_clr = 1'b0;
   logic          step;
   logic          dir;
   logic [CW-1:0] pos_out;
   logic          overflow;
   logic          err;

   quad_decoder #(
      .counter_size (CW),
      .filter_cycles(FC)
   ) dut (
      .clk     (clk),
      .res_n   (res_n),
      .enable  (enable),
      .a_in    (a_in),
      .b_in    (b_in),
      .load    (load),
      .pos_in  (pos_in),
      .err_clr (err_clr),
      .step    (step),
      .dir     (dir),
      .pos_out (pos_out),
      .overflow(overflow),
      .err     (err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Up-counting Gray sequence of {a,b}
   bit [1:0] SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

   function automatic int gpos(input bit [1:0] ab);
      for (int i = 0; i < 4; i++) if (SEQ[i] == ab) return i;
      return 0;
   endfunction

   // A channel settles once its last FC synced samples all disagree
   function automatic bit settled(input bit q[$], input bit f);
      if (q.size() < FC) return 1'b0;
      foreach (q[i]) if (q[i] == f) return 1'b0;
      return 1'b1;
   endfunction

   bit            m_init;
   int            m_edges;
   bit            m_a1, m_a2, m_b1, m_b2;
   bit            m_fa, m_fb;
   bit            m_ha[$];
   bit            m_hb[$];
   bit [1:0]      m_prev;
   bit            m_step, m_dir, m_ovf, m_err;
   logic [CW-1:0] m_pos;

   task automatic model_edge();
      bit [1:0] cur;
      int       dd;
      if (!res_n) begin
         m_init = 1; m_edges = 0;
         m_a1 = 0; m_a2 = 0; m_b1 = 0; m_b2 = 0;
         m_fa = 0; m_fb = 0; m_prev = 0;
         m_ha.delete(); m_hb.delete();
         m_step = 0; m_dir = 0; m_ovf = 0; m_err = 0; m_pos = '0;
         return;
      end
      cur = {m_fa, m_fb};
      dd = m_init ? 0 : (gpos(cur) - gpos(m_prev) + 4) % 4;
      m_step = 0;
      m_ovf = 0;
      if (load) begin
         m_pos = pos_in;
      end else if (enable && dd == 1) begin
         m_step = 1; m_dir = 1; m_ovf = (m_pos == '1); m_pos = m_pos + 1;
      end else if (enable && dd == 3) begin
         m_step = 1; m_dir = 0; m_ovf = (m_pos == '0); m_pos = m_pos - 1;
      end
      if (dd == 2) m_err = 1;
      else if (err_clr) m_err = 0;
      if (m_init) begin
         m_fa = m_a2; m_fb = m_b2;
         m_prev = {m_a2, m_b2};
         m_edges++;
         if (m_edges == FC + 2) m_init = 0;
      end else begin
         m_prev = cur;
         m_ha.push_back(m_a2);
         m_hb.push_back(m_b2);
         if (m_ha.size() > FC) void'(m_ha.pop_front());
         if (m_hb.size() > FC) void'(m_hb.pop_front());
         if (settled(m_ha, m_fa)) m_fa = ~m_fa;
         if (settled(m_hb, m_fb)) m_fb = ~m_fb;
      end
      m_a2 = m_a1; m_b2 = m_b1;
      m_a1 = a_in; m_b1 = b_in;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("step", step, m_step);
      check("dir", dir, m_dir);
      check("pos", pos_out, m_pos);
      check("ovf", overflow, m_ovf);
      check("err", err, m_err);
   endtask

   int lat, nstep, novf, seen;

   task automatic drive(input bit [1:0] ab, input int n);
      a_in = ab[1];
      b_in = ab[0];
      lat = 0; nstep = 0; novf = 0;
      for (int i = 1; i <= n; i++) begin
         cyc();
         if (step) begin
            nstep++;
            if (lat == 0) lat = i;
         end
         if (overflow) novf++;
      end
   endtask

   bit [1:0] cur_ab;
   int       hold;

   initial begin
      // Reset with both channels high
      a_in = 1; b_in = 1; res_n = 0;
      repeat (3) cyc();
      res_n = 1;
      seen = 0;
      repeat (10) begin
         cyc();
         seen |= step;
      end
      check("rst_pos", pos_out, 0);
      check("rst_step_seen", seen, 0);
      check("rst_err", err, 0);
      check("rst_ovf", overflow, 0);

      // Mid-run reset with channels at 00
      res_n = 0; a_in = 0; b_in = 0;
      repeat (2) cyc();
      res_n = 1;
      repeat (10) cyc();

      // Four up steps, each FC+2 edges after capture
      for (int i = 1; i < 5; i++) begin
         drive(SEQ[i % 4], 8);
         check("up_lat", lat, FC + 3);
         check("up_n", nstep, 1);
      end
      check("up_dir", dir, 1);
      check("up_pos", pos_out, 4);

      // Four down steps, then wrap below zero
      for (int i = 3; i >= 0; i--) begin
         drive(SEQ[i], 8);
         check("dn_n", nstep, 1);
      end
      check("dn_dir", dir, 0);
      check("dn_pos", pos_out, 0);
      drive(2'b10, 8);
      check("wrap_pos", pos_out, 32'hFFFF_FFFF);
      check("wrap_ovf", novf, 1);

      // Short glitch is rejected, FC-long pulse is two steps
      drive(2'b00, 3);
      drive(2'b10, 12);
      check("glitch_pos", pos_out, 32'hFFFF_FFFF);
      check("glitch_err", err, 0);
      drive(2'b00, 4);
      seen = nstep;
      drive(2'b10, 12);
      check("pulse_steps", seen + nstep, 2);
      check("pulse_pos", pos_out, 32'hFFFF_FFFF);

      // Illegal double change, clear, then clear colliding with a new error
      drive(2'b00, 8);
      drive(2'b11, 10);
      check("ill_step", nstep, 0);
      check("ill_err", err, 1);
      err_clr = 1;
      cyc();
      err_clr = 0;
      cyc();
      check("clr_err", err, 0);
      err_clr = 1;
      drive(2'b00, FC + 3);
      err_clr = 0;
      check("clr_vs_set", err, 1);
      drive(2'b00, 3);

      // Load near wrap, then one up step wraps to zero
      load = 1; pos_in = '1;
      cyc();
      load = 0;
      check("load_pos", pos_out, 32'hFFFF_FFFF);
      drive(2'b01, 8);
      check("ld_wrap_pos", pos_out, 0);
      check("ld_wrap_ovf", novf, 1);

      // Load coincident with a decoded step
      drive(2'b11, FC + 2);
      load = 1; pos_in = 32'h1234_5678;
      cyc();
      load = 0;
      check("ld_co_step", step, 0);
      check("ld_co_pos", pos_out, 32'h1234_5678);
      drive(2'b11, 5);
      check("ld_co_late", nstep, 0);

      // Disabled steps are tracked silently
      enable = 0;
      drive(2'b10, 8);
      seen = nstep;
      drive(2'b00, 8);
      check("dis_steps", seen + nstep, 0);
      check("dis_pos", pos_out, 32'h1234_5678);
      enable = 1;
      drive(2'b00, 10);
      check("reen_steps", nstep, 0);

      // Random traffic, mostly legal neighbours
      cur_ab = 2'b00;
      repeat (300) begin
         if ($urandom_range(0, 9) < 7)
            cur_ab = SEQ[(gpos(cur_ab) + ($urandom_range(0, 1) ? 1 : 3)) % 4];
         else
            cur_ab = 2'($urandom_range(0, 3));
         a_in = cur_ab[1];
         b_in = cur_ab[0];
         enable = ($urandom_range(0, 9) != 0);
         hold = $urandom_range(1, 12);
         repeat (hold) begin
            load = ($urandom_range(0, 29) == 0);
            pos_in = ($urandom_range(0, 2) == 0) ? '1 : CW'($urandom);
            err_clr = ($urandom_range(0, 9) == 0);
            res_n = ($urandom_range(0, 299) != 0);
            cyc();
         end
      end
      res_n = 1; load = 0; err_clr = 0;
      repeat (20) cyc();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
